// File: rtl/regfile_mp.sv
// Multi-port register file with write-to-read bypass and per-register busy scoreboard.
// Optional debug read port (stored values, no bypass) enabled by defining REGFILE_DBG_EN.
module regfile_mp #(
  parameter int ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH    = 32,
  parameter int NUM_RD        = 2,
  parameter int TAP_IDX       = 10
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              we0,
  input  logic [ADDRESS_WIDTH-1:0]          waddr0,
  input  logic [DATA_WIDTH-1:0]             wdata0,
  input  logic                              we1,
  input  logic [ADDRESS_WIDTH-1:0]          waddr1,
  input  logic [DATA_WIDTH-1:0]             wdata1,
  input  logic                              busy_set,
  input  logic [ADDRESS_WIDTH-1:0]          busy_addr,
  input  logic [NUM_RD*ADDRESS_WIDTH-1:0]   raddr,
  output logic [NUM_RD*DATA_WIDTH-1:0]      rdata,
  output logic [NUM_RD-1:0]                 rbusy,
  output logic [DATA_WIDTH-1:0]             tap_data
`ifdef REGFILE_DBG_EN
  ,
  input  logic [ADDRESS_WIDTH-1:0]          dbg_addr,
  output logic [DATA_WIDTH-1:0]             dbg_data,
  output logic                              dbg_busy
`endif
);

  localparam int DEPTH = 2 ** ADDRESS_WIDTH;
  localparam logic [ADDRESS_WIDTH-1:0] TAP_A = ADDRESS_WIDTH'(TAP_IDX);

  logic [DATA_WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0]      busy;
  logic [DEPTH-1:0]      busy_nxt;
  logic                  wr0_act;
  logic                  wr1_act;

  // Writes are suppressed while in reset so bypass cannot leak data onto the read ports.
  assign wr0_act = rst_n && we0 && (waddr0 != '0);
  assign wr1_act = rst_n && we1 && (waddr1 != '0);

  // Port 1 (load) is younger, so it takes priority over port 0 on a shared address.
  function automatic logic [DATA_WIDTH-1:0] read_byp(input logic [ADDRESS_WIDTH-1:0] a);
    logic [DATA_WIDTH-1:0] v;
    v = regs[a];
    if (wr0_act && (waddr0 == a)) v = wdata0;
    if (wr1_act && (waddr1 == a)) v = wdata1;
    return v;
  endfunction

  function automatic logic busy_byp(input logic [ADDRESS_WIDTH-1:0] a);
    logic b;
    b = busy[a];
    if ((wr0_act && (waddr0 == a)) || (wr1_act && (waddr1 == a))) b = 1'b0;
    return b;
  endfunction

  always_comb begin
    busy_nxt = busy;
    for (int r = 1; r < DEPTH; r++) begin
      if (busy_set && (busy_addr == ADDRESS_WIDTH'(r))) begin
        busy_nxt[r] = 1'b1;
      end else if ((wr0_act && (waddr0 == ADDRESS_WIDTH'(r))) ||
                   (wr1_act && (waddr1 == ADDRESS_WIDTH'(r)))) begin
        busy_nxt[r] = 1'b0;
      end
    end
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < DEPTH; r++) regs[r] <= '0;
      busy <= '0;
    end else begin
      if (wr0_act) regs[waddr0] <= wdata0;
      if (wr1_act) regs[waddr1] <= wdata1;
      busy <= busy_nxt;
    end
  end

  always_comb begin
    rdata = '0;
    rbusy = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      rdata[i*DATA_WIDTH +: DATA_WIDTH] = read_byp(raddr[i*ADDRESS_WIDTH +: ADDRESS_WIDTH]);
      rbusy[i]                          = busy_byp(raddr[i*ADDRESS_WIDTH +: ADDRESS_WIDTH]);
    end
  end

  assign tap_data = read_byp(TAP_A);

`ifdef REGFILE_DBG_EN
  assign dbg_data = regs[dbg_addr];
  assign dbg_busy = busy[dbg_addr];
`endif

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: directed vectors push expected values, a negedge monitor checks.
module tb_regfile_mp;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NR = 2;

  localparam int SIG_RDATA = 0;
  localparam int SIG_RBUSY = 1;
  localparam int SIG_TAP   = 2;
  localparam int SIG_DDATA = 3;
  localparam int SIG_DBUSY = 4;

  logic             clk;
  logic             rst_n;
  logic             we0, we1, busy_set;
  logic [AW-1:0]    waddr0, waddr1, busy_addr;
  logic [DW-1:0]    wdata0, wdata1;
  logic [NR*AW-1:0] raddr;
  logic [NR*DW-1:0] rdata;
  logic [NR-1:0]    rbusy;
  logic [DW-1:0]    tap_data;
`ifdef REGFILE_DBG_EN
  logic [AW-1:0]    dbg_addr;
  logic [DW-1:0]    dbg_data;
  logic             dbg_busy;
`endif

  regfile_mp #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .NUM_RD(NR), .TAP_IDX(10)) dut (
    .clk(clk), .rst_n(rst_n),
    .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
    .busy_set(busy_set), .busy_addr(busy_addr),
    .raddr(raddr), .rdata(rdata), .rbusy(rbusy), .tap_data(tap_data)
`ifdef REGFILE_DBG_EN
    , .dbg_addr(dbg_addr), .dbg_data(dbg_data), .dbg_busy(dbg_busy)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int          sig;
    int          idx;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic expect_val(input string name, input int sig, input int idx, input logic [31:0] val);
    exp_t e;
    e.name = name; e.sig = sig; e.idx = idx; e.val = val;
    sb.push_back(e);
  endtask

  function automatic logic [31:0] actual(input int sig, input int idx);
    logic [31:0] a;
    a = 'x;
    case (sig)
      SIG_RDATA: a = rdata[idx*DW +: DW];
      SIG_RBUSY: a = {31'd0, rbusy[idx]};
      SIG_TAP:   a = tap_data;
`ifdef REGFILE_DBG_EN
      SIG_DDATA: a = dbg_data;
      SIG_DBUSY: a = {31'd0, dbg_busy};
`endif
      default:   a = 'x;
    endcase
    return a;
  endfunction

  // Monitor: outputs are combinational, so each negedge presents a settled result set.
  exp_t        mon_e;
  logic [31:0] mon_a;
  initial begin
    forever begin
      @(negedge clk);
      while (sb.size() > 0) begin
        mon_e = sb.pop_front();
        mon_a = actual(mon_e.sig, mon_e.idx);
        n_checks++;
        if (mon_a !== mon_e.val) begin
          n_fail++;
          $display("FAIL %s: got 0x%08h, expected 0x%08h", mon_e.name, mon_a, mon_e.val);
        end
      end
    end
  end

  task automatic idle();
    we0 = 1'b0; waddr0 = '0; wdata0 = '0;
    we1 = 1'b0; waddr1 = '0; wdata1 = '0;
    busy_set = 1'b0; busy_addr = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_raddr(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    raddr = {a1, a0};
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    set_raddr(5'd3, 5'd9);
`ifdef REGFILE_DBG_EN
    dbg_addr = 5'd10;
`endif
    // Reset state
    expect_val("reset_rdata0", SIG_RDATA, 0, 32'h0);
    expect_val("reset_rdata1", SIG_RDATA, 1, 32'h0);
    expect_val("reset_rbusy0", SIG_RBUSY, 0, 32'h0);
    expect_val("reset_rbusy1", SIG_RBUSY, 1, 32'h0);
    expect_val("reset_tap",    SIG_TAP,   0, 32'h0);
    step();
    step();
    rst_n = 1'b1;

    // Bypass of a single write, then stored value
    step();
    we0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'hDEADBEEF;
    set_raddr(5'd5, 5'd0);
    expect_val("byp_w0_rdata0", SIG_RDATA, 0, 32'hDEADBEEF);
    expect_val("byp_r0_rdata1", SIG_RDATA, 1, 32'h0);
    step();
    idle();
    expect_val("stored_w0", SIG_RDATA, 0, 32'hDEADBEEF);

    // Same-address dual write: port 1 wins
    step();
    we0 = 1'b1; waddr0 = 5'd7; wdata0 = 32'h11;
    we1 = 1'b1; waddr1 = 5'd7; wdata1 = 32'h22;
    set_raddr(5'd7, 5'd5);
    expect_val("dual_byp", SIG_RDATA, 0, 32'h22);
    expect_val("dual_other_port", SIG_RDATA, 1, 32'hDEADBEEF);
    step();
    idle();
    expect_val("dual_stored", SIG_RDATA, 0, 32'h22);

    // Distinct-address dual write
    step();
    we0 = 1'b1; waddr0 = 5'd12; wdata0 = 32'h0000AAAA;
    we1 = 1'b1; waddr1 = 5'd13; wdata1 = 32'h0000BBBB;
    set_raddr(5'd12, 5'd13);
    expect_val("split_byp0", SIG_RDATA, 0, 32'h0000AAAA);
    expect_val("split_byp1", SIG_RDATA, 1, 32'h0000BBBB);
    step();
    idle();
    expect_val("split_st0", SIG_RDATA, 0, 32'h0000AAAA);
    expect_val("split_st1", SIG_RDATA, 1, 32'h0000BBBB);

    // Register 0 ignores writes and busy_set
    step();
    we0 = 1'b1; waddr0 = 5'd0; wdata0 = 32'h1234;
    busy_set = 1'b1; busy_addr = 5'd0;
    set_raddr(5'd0, 5'd0);
    expect_val("r0_byp_rdata", SIG_RDATA, 0, 32'h0);
    expect_val("r0_byp_rbusy", SIG_RBUSY, 0, 32'h0);
    step();
    idle();
    expect_val("r0_st_rdata", SIG_RDATA, 0, 32'h0);
    expect_val("r0_st_rbusy", SIG_RBUSY, 0, 32'h0);

    // Busy scoreboard
    step();
    busy_set = 1'b1; busy_addr = 5'd9;
    set_raddr(5'd0, 5'd9);
    expect_val("busy_set_same_cycle", SIG_RBUSY, 1, 32'h0);
    step();
    idle();
    expect_val("busy_after_set", SIG_RBUSY, 1, 32'h1);
    step();
    we1 = 1'b1; waddr1 = 5'd9; wdata1 = 32'd99;
    expect_val("busy_clr_comb", SIG_RBUSY, 1, 32'h0);
    expect_val("busy_clr_data", SIG_RDATA, 1, 32'd99);
    step();
    idle();
    expect_val("busy_after_clr", SIG_RBUSY, 1, 32'h0);
    step();
    busy_set = 1'b1; busy_addr = 5'd9;
    we0 = 1'b1; waddr0 = 5'd9; wdata0 = 32'd77;
    expect_val("setclr_comb", SIG_RBUSY, 1, 32'h0);
    expect_val("setclr_data", SIG_RDATA, 1, 32'd77);
    step();
    idle();
    expect_val("setclr_set_wins", SIG_RBUSY, 1, 32'h1);
    step();
    we0 = 1'b1; waddr0 = 5'd3; wdata0 = 32'd5;
    expect_val("busy_hold_other_wr", SIG_RBUSY, 1, 32'h1);
    step();
    idle();

    // Tap register and debug port
    step();
    we0 = 1'b1; waddr0 = 5'd10; wdata0 = 32'd42;
    expect_val("tap_byp", SIG_TAP, 0, 32'd42);
`ifdef REGFILE_DBG_EN
    dbg_addr = 5'd10;
    expect_val("dbg_before_edge", SIG_DDATA, 0, 32'd0);
`endif
    step();
    idle();
    expect_val("tap_stored", SIG_TAP, 0, 32'd42);
`ifdef REGFILE_DBG_EN
    expect_val("dbg_after_edge", SIG_DDATA, 0, 32'd42);
    dbg_addr = 5'd9;
    expect_val("dbg_busy9", SIG_DBUSY, 0, 32'd1);
`endif

    // Reset mid-operation with a write in flight
    step();
    we0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'd55;
    set_raddr(5'd5, 5'd9);
    rst_n = 1'b0;
    expect_val("rst_mid_rdata0", SIG_RDATA, 0, 32'h0);
    expect_val("rst_mid_rbusy1", SIG_RBUSY, 1, 32'h0);
    expect_val("rst_mid_tap",    SIG_TAP,   0, 32'h0);
    step();
    idle();
    rst_n = 1'b1;
    expect_val("rst_rel_rdata0", SIG_RDATA, 0, 32'h0);
    expect_val("rst_rel_rbusy1", SIG_RBUSY, 1, 32'h0);
    step();
    we0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'd66;
    step();
    idle();
    expect_val("post_rst_write", SIG_RDATA, 0, 32'd66);

    step();
    step();
    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL sb_drain: got %0d pending entries, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
